// File: rtl/bp_be_scoreboard_counting.sv
// bp_be_scoreboard_counting
//   Counting register scoreboard. Each architectural register keeps the number
//   of writes still in flight, so several long-latency writebacks to the same
//   destination can be outstanding while sources and destinations are still
//   hazard-checked.
//
//   Ports
//     clk_i, reset_n_i       clock, asynchronous active-low reset
//     score_v_i/score_rd_i   up to num_score_p allocations per cycle
//     clear_v_i/clear_rd_i   up to num_clear_p writeback clears per cycle
//     flush_i                zero every counter next cycle
//     rs_i / rs_match_o      source lookups (pending write exists)
//     rd_i / rd_match_o      destination lookup (pending write exists)
//     rd_full_o              destination already has max_pending_p writes
//     busy_o                 any counter nonzero
//     err_o                  sticky saturation/underflow flag
//
//   Lookups are purely combinational from the registered counters; a score or
//   clear becomes visible one cycle after it is sampled.

// Per-register counter. Sums the matching score/clear ports, applies the net
// delta and clamps to [0, max_pending_p], raising err_o when it had to clamp.
module bp_be_scoreboard_entry
  #(parameter int entry_p          = 1
   ,parameter int reg_addr_width_p = 5
   ,parameter int num_score_p      = 1
   ,parameter int num_clear_p      = 2
   ,parameter int max_pending_p    = 3
   ,parameter int cnt_w_p          = 2
   )
   (input  logic                                         clk_i
   ,input  logic                                         reset_n_i
   ,input  logic [num_score_p-1:0]                       score_v_i
   ,input  logic [num_score_p-1:0][reg_addr_width_p-1:0] score_rd_i
   ,input  logic [num_clear_p-1:0]                       clear_v_i
   ,input  logic [num_clear_p-1:0][reg_addr_width_p-1:0] clear_rd_i
   ,input  logic                                         flush_i
   ,output logic [cnt_w_p-1:0]                           cnt_o
   ,output logic                                         err_o
   );

   // Sum width covers every port hitting this entry at once; the next-value
   // word adds a sign bit on top of counter + sum so no intermediate wraps.
   localparam int sum_w = $clog2(num_score_p + num_clear_p + 1);
   localparam int nw    = cnt_w_p + sum_w + 1;

   logic [sum_w-1:0]         inc, dec;
   logic signed [nw-1:0]     n;
   logic                     ovf, unf;
   logic [cnt_w_p-1:0]       cnt_n;

   always_comb begin
      inc = '0;
      dec = '0;
      for (int i = 0; i < num_score_p; i++)
         if (score_v_i[i] && (score_rd_i[i] == reg_addr_width_p'(entry_p)))
            inc = inc + sum_w'(1);
      for (int i = 0; i < num_clear_p; i++)
         if (clear_v_i[i] && (clear_rd_i[i] == reg_addr_width_p'(entry_p)))
            dec = dec + sum_w'(1);
   end

   always_comb begin
      n     = $signed(nw'(cnt_o)) + $signed(nw'(inc)) - $signed(nw'(dec));
      unf   = n[nw-1];
      ovf   = !n[nw-1] && (n[nw-2:0] > (nw-1)'(max_pending_p));
      cnt_n = unf ? '0
            : ovf ? cnt_w_p'(max_pending_p)
            : n[cnt_w_p-1:0];
      // A flush discards this cycle's traffic, so nothing it carried can err.
      err_o = !flush_i && (ovf || unf);
   end

   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i)   cnt_o <= '0;
      else if (flush_i) cnt_o <= '0;
      else              cnt_o <= cnt_n;

endmodule

module bp_be_scoreboard_counting
  #(parameter int bp_params_p   = 0   // 0 = e_bp_default_cfg
   ,parameter int num_rs_p      = 2
   ,parameter int num_score_p   = 1
   ,parameter int num_clear_p   = 2
   ,parameter int max_pending_p = 3
   ,parameter int zero_reg_p    = 1
   // Every supported configuration uses a 32-entry integer register file.
   ,localparam int reg_addr_width_gp = (bp_params_p == 0) ? 5 : 5
   ,localparam int cnt_w             = $clog2(max_pending_p + 1)
   )
   (input  logic                                          clk_i
   ,input  logic                                          reset_n_i
   ,input  logic [num_score_p-1:0]                        score_v_i
   ,input  logic [num_score_p-1:0][reg_addr_width_gp-1:0] score_rd_i
   ,input  logic [num_clear_p-1:0]                        clear_v_i
   ,input  logic [num_clear_p-1:0][reg_addr_width_gp-1:0] clear_rd_i
   ,input  logic                                          flush_i
   ,input  logic [num_rs_p-1:0][reg_addr_width_gp-1:0]    rs_i
   ,input  logic [reg_addr_width_gp-1:0]                  rd_i
   ,output logic [num_rs_p-1:0]                           rs_match_o
   ,output logic                                          rd_match_o
   ,output logic                                          rd_full_o
   ,output logic                                          busy_o
   ,output logic                                          err_o
   );

   localparam int num_regs = 1 << reg_addr_width_gp;

   logic [num_regs-1:0][cnt_w-1:0] cnt;
   logic [num_regs-1:0]            nz;
   logic [num_regs-1:0]            err_set;
   logic                           err_r;

   for (genvar e = 0; e < num_regs; e++) begin : g_ent
      if (e == 0 && zero_reg_p != 0) begin : g_zero
         // Hardwired zero register: never pending, never flags.
         assign cnt[e]     = '0;
         assign err_set[e] = 1'b0;
      end else begin : g_cnt
         bp_be_scoreboard_entry
           #(.entry_p          (e)
            ,.reg_addr_width_p (reg_addr_width_gp)
            ,.num_score_p      (num_score_p)
            ,.num_clear_p      (num_clear_p)
            ,.max_pending_p    (max_pending_p)
            ,.cnt_w_p          (cnt_w)
            )
          u_ent
           (.clk_i      (clk_i)
           ,.reset_n_i  (reset_n_i)
           ,.score_v_i  (score_v_i)
           ,.score_rd_i (score_rd_i)
           ,.clear_v_i  (clear_v_i)
           ,.clear_rd_i (clear_rd_i)
           ,.flush_i    (flush_i)
           ,.cnt_o      (cnt[e])
           ,.err_o      (err_set[e])
           );
      end
      assign nz[e] = |cnt[e];
   end

   // Sticky: only reset clears it; flush leaves it alone.
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) err_r <= 1'b0;
      else            err_r <= err_r | (|err_set);

   always_comb begin
      rs_match_o = '0;
      for (int i = 0; i < num_rs_p; i++)
         rs_match_o[i] = nz[rs_i[i]];
   end

   assign rd_match_o = nz[rd_i];
   assign rd_full_o  = (cnt[rd_i] == cnt_w'(max_pending_p));
   assign busy_o     = |nz;
   assign err_o      = err_r;

endmodule

// File: tb/tb_bp_be_scoreboard_counting.sv
module tb_bp_be_scoreboard_counting;
   localparam int AW  = 5;
   localparam int NR  = 32;
   localparam int NRS = 2;
   localparam int NSC = 1;
   localparam int NCL = 2;
   localparam int MP  = 3;

   logic                     clk_i = 1'b0;
   logic                     reset_n_i;
   logic [NSC-1:0]           score_v_i;
   logic [NSC-1:0][AW-1:0]   score_rd_i;
   logic [NCL-1:0]           clear_v_i;
   logic [NCL-1:0][AW-1:0]   clear_rd_i;
   logic                     flush_i;
   logic [NRS-1:0][AW-1:0]   rs_i;
   logic [AW-1:0]            rd_i;
   logic [NRS-1:0]           rs_match_o;
   logic                     rd_match_o, rd_full_o, busy_o, err_o;

   bp_be_scoreboard_counting dut
     (.clk_i      (clk_i)
     ,.reset_n_i  (reset_n_i)
     ,.score_v_i  (score_v_i)
     ,.score_rd_i (score_rd_i)
     ,.clear_v_i  (clear_v_i)
     ,.clear_rd_i (clear_rd_i)
     ,.flush_i    (flush_i)
     ,.rs_i       (rs_i)
     ,.rd_i       (rd_i)
     ,.rs_match_o (rs_match_o)
     ,.rd_match_o (rd_match_o)
     ,.rd_full_o  (rd_full_o)
     ,.busy_o     (busy_o)
     ,.err_o      (err_o)
     );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;
   int cnt_m [NR];
   bit err_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit any_pending();
      for (int e = 0; e < NR; e++) if (cnt_m[e] != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_outs();
      for (int i = 0; i < NRS; i++)
         chk($sformatf("rs_match[%0d] r%0d", i, rs_i[i]), 32'(rs_match_o[i]), 32'(cnt_m[rs_i[i]] != 0));
      chk($sformatf("rd_match r%0d", rd_i), 32'(rd_match_o), 32'(cnt_m[rd_i] != 0));
      chk($sformatf("rd_full r%0d", rd_i),  32'(rd_full_o),  32'(cnt_m[rd_i] == MP));
      chk("busy", 32'(busy_o), 32'(any_pending()));
      chk("err",  32'(err_o),  32'(err_m));
   endtask

   // Reference: each cycle apply net (scores - clears) per register, clamp to
   // [0, MP] and remember that clamping happened; flush wipes everything.
   task automatic model_step();
      if (flush_i) begin
         for (int e = 0; e < NR; e++) cnt_m[e] = 0;
      end else begin
         for (int e = 1; e < NR; e++) begin
            int n;
            n = cnt_m[e];
            for (int p = 0; p < NSC; p++) if (score_v_i[p] && score_rd_i[p] == AW'(e)) n++;
            for (int p = 0; p < NCL; p++) if (clear_v_i[p] && clear_rd_i[p] == AW'(e)) n--;
            if (n > MP)     begin n = MP; err_m = 1'b1; end
            else if (n < 0) begin n = 0;  err_m = 1'b1; end
            cnt_m[e] = n;
         end
      end
   endtask

   task automatic cycle();
      #1 check_outs();
      @(posedge clk_i);
      model_step();
      @(negedge clk_i);
   endtask

   task automatic idle();
      score_v_i = '0; clear_v_i = '0; flush_i = 1'b0;
   endtask

   task automatic score(input int r);
      score_v_i[0] = 1'b1; score_rd_i[0] = AW'(r);
   endtask

   task automatic clear(input int p, input int r);
      clear_v_i[p] = 1'b1; clear_rd_i[p] = AW'(r);
   endtask

   // Asserted between edges so the asynchronous path is exercised.
   task automatic do_reset();
      idle();
      reset_n_i = 1'b0;
      for (int e = 0; e < NR; e++) cnt_m[e] = 0;
      err_m = 1'b0;
      #1 check_outs();
      @(posedge clk_i);
      #1 check_outs();
      @(negedge clk_i);
      reset_n_i = 1'b1;
   endtask

   initial begin
      reset_n_i = 1'b0;
      idle();
      score_rd_i = '0; clear_rd_i = '0; rs_i = '0; rd_i = '0;
      @(negedge clk_i);
      do_reset();

      // Score r5: invisible in the scoring cycle, visible the next.
      rs_i[0] = 5; score(5);
      #1 chk("t1_rs_same_cycle", 32'(rs_match_o[0]), 0);
      cycle(); idle();
      #1 chk("t1_rs_next", 32'(rs_match_o[0]), 1);
      chk("t1_busy", 32'(busy_o), 1);
      cycle();

      // Three scores of r7 saturate; one clear drops to 2.
      do_reset();
      rd_i = 7;
      for (int k = 0; k < 3; k++) begin score(7); cycle(); end
      idle(); clear(0, 7);
      #1 chk("t2_full", 32'(rd_full_o), 1);
      cycle(); idle();
      #1 chk("t2_not_full", 32'(rd_full_o), 0);
      chk("t2_match", 32'(rd_match_o), 1);
      cycle();

      // Net delta on r3: 2 +1 -2 = 1 clean, then 1 -2 underflows.
      do_reset();
      rs_i[1] = 3;
      score(3); cycle(); cycle();
      clear(0, 3); clear(1, 3); cycle(); idle();
      #1 chk("t3_cnt1", 32'(rs_match_o[1]), 1);
      chk("t3_no_err", 32'(err_o), 0);
      clear(0, 3); clear(1, 3); cycle(); idle();
      #1 chk("t3_underflow_err", 32'(err_o), 1);
      chk("t3_cnt0", 32'(rs_match_o[1]), 0);
      cycle(); cycle();
      chk("t3_sticky", 32'(err_o), 1);

      // Overflow on r9 clamps at 3 and flags.
      do_reset();
      rd_i = 9;
      for (int k = 0; k < 4; k++) begin score(9); cycle(); end
      idle();
      #1 chk("t4_ovf_err", 32'(err_o), 1);
      chk("t4_clamped_full", 32'(rd_full_o), 1);
      cycle();

      // Zero register is never scored.
      do_reset();
      rs_i[0] = 0;
      score(0); cycle(); idle();
      #1 chk("t5_r0_match", 32'(rs_match_o[0]), 0);
      chk("t5_r0_err", 32'(err_o), 0);
      cycle();

      // Flush wins over a same-cycle score.
      do_reset();
      rs_i[0] = 6; rs_i[1] = 2;
      score(2); cycle(); cycle(); score(4); cycle();
      idle(); flush_i = 1'b1; score(6); cycle(); idle();
      #1 chk("t6_busy", 32'(busy_o), 0);
      chk("t6_r6", 32'(rs_match_o[0]), 0);
      cycle();

      // Random traffic concentrated on a few registers to provoke hazards.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(199) == 0) begin
            do_reset();
         end else begin
            for (int p = 0; p < NSC; p++) begin
               score_v_i[p]  = ($urandom_range(1) == 1);
               score_rd_i[p] = AW'(($urandom_range(7) == 0) ? $urandom_range(31) : $urandom_range(7));
            end
            for (int p = 0; p < NCL; p++) begin
               clear_v_i[p]  = ($urandom_range(2) == 0);
               clear_rd_i[p] = AW'(($urandom_range(7) == 0) ? $urandom_range(31) : $urandom_range(7));
            end
            flush_i = ($urandom_range(23) == 0);
            for (int i = 0; i < NRS; i++) rs_i[i] = AW'($urandom_range(7));
            rd_i = AW'($urandom_range(7));
            cycle();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
